// File: rtl/tdm_demux.sv
// De-interleaves framed bit-serial TDM data into LANES words of WIDTH bits.
// Latency: 1 cycle from the last frame bit to out_valid. A frame completing while the output is still full is dropped and sets sticky overrun.
module tdm_demux #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sin,
  input  logic                   sin_valid,
  input  logic                   frame_start,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   ovr_clr,
  output logic                   overrun,
  output logic                   sync_err
);

  localparam int F  = LANES * WIDTH;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [WW-1:0] LAST_BIT  = WW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [WW-1:0] bit_q, bit_d;
  logic [F-1:0]  buf_q, buf_d;
  logic [F-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          sync_err_q, sync_err_d;
  logic          complete;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    bit_d       = bit_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    sync_err_d  = 1'b0;
    complete    = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (ovr_clr) overrun_d = 1'b0;

    if (sin_valid) begin
      if (frame_start) begin
        // A frame_start always restarts assembly; mid-frame it abandons the partial frame.
        if (state_q == SHIFT) sync_err_d = 1'b1;
        buf_d    = '0;
        buf_d[0] = sin;
        lane_d   = LW'(1);
        bit_d    = '0;
        state_d  = SHIFT;
      end else if (state_q == SHIFT) begin
        for (int l = 0; l < LANES; l++) begin
          for (int b = 0; b < WIDTH; b++) begin
            if (lane_q == LW'(l) && bit_q == WW'(b)) buf_d[l*WIDTH+b] = sin;
          end
        end
        if (lane_q == LAST_LANE && bit_q == LAST_BIT) begin
          complete = 1'b1;
          state_d  = IDLE;
          lane_d   = '0;
          bit_d    = '0;
        end else if (lane_q == LAST_LANE) begin
          lane_d = '0;
          bit_d  = bit_q + WW'(1);
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
    end

    // Drop wins over clear so a lost frame is never silently forgotten.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = buf_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      bit_q       <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      bit_q       <= bit_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with LANES=2, WIDTH=8; inputs change and outputs are sampled on the falling edge.
module tb_tdm_demux;

  localparam int LANES = 2;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sin;
  logic                   sin_valid;
  logic                   frame_start;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   ovr_clr;
  logic                   overrun;
  logic                   sync_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdm_demux #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .frame_start(frame_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovr_clr    (ovr_clr),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame bit k carries bit k/2 of lane k%2.
  function automatic logic fbit(input logic [15:0] f, input int k);
    return f[(k % LANES) * WIDTH + (k / LANES)];
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    sin         = b;
    sin_valid   = 1'b1;
    frame_start = fs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sin_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f, input int gap_every);
    for (int k = 0; k < LANES * WIDTH; k++) begin
      send_bit(fbit(f, k), k == 0);
      if (gap_every > 0 && k < LANES * WIDTH - 1 && (k % gap_every) == gap_every - 1)
        idle(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] b2b [4];
    b2b[0] = 16'h0001; b2b[1] = 16'h8000; b2b[2] = 16'hFFFF; b2b[3] = 16'h5AA5;

    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; ovr_clr = 1'b0;

    // 1: reset with random serial activity
    for (int i = 0; i < 3; i++) begin
      sin = 1'($urandom); sin_valid = 1'($urandom); frame_start = 1'($urandom);
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
    end
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 2: basic frame, no stalls
    for (int k = 0; k < 15; k++) send_bit(fbit(16'h3CA5, k), k == 0);
    chk("basic_valid_early", 32'(out_valid), 32'd0);
    send_bit(fbit(16'h3CA5, 15), 1'b0);
    sin_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h3CA5);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("basic_consumed", 32'(out_valid), 32'd0);

    // 3: stalled input, then held output under backpressure
    send_frame(16'h3CA5, 3);
    sin_valid = 1'b0;
    chk("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("bp_data", 32'(out_data), 32'h3CA5);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("bp_release", 32'(out_valid), 32'd0);

    // 4: overrun, clear, and clear colliding with a drop
    send_frame(16'h3CA5, 0);
    sin_valid = 1'b0;
    chk("ovr_first_valid", 32'(out_valid), 32'd1);
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    send_frame(16'h1234, 0);
    sin_valid = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_data_kept", 32'(out_data), 32'h3CA5);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    ovr_clr = 1'b1;
    send_frame(16'h1234, 0);
    ovr_clr = 1'b0;
    sin_valid = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    chk("ovr_data_kept2", 32'(out_data), 32'h3CA5);
    ovr_clr = 1'b1; out_ready = 1'b1;
    idle(1);
    ovr_clr = 1'b0; out_ready = 1'b0;
    chk("ovr_cleanup", 32'(overrun), 32'd0);
    chk("ovr_drained", 32'(out_valid), 32'd0);

    // 5: resync at bit 6
    for (int k = 0; k < 6; k++) send_bit(fbit(16'h1234, k), k == 0);
    chk("resync_no_err_yet", 32'(sync_err), 32'd0);
    send_bit(fbit(16'h00FF, 0), 1'b1);
    chk("resync_pulse", 32'(sync_err), 32'd1);
    send_bit(fbit(16'h00FF, 1), 1'b0);
    chk("resync_pulse_end", 32'(sync_err), 32'd0);
    for (int k = 2; k < 15; k++) send_bit(fbit(16'h00FF, k), 1'b0);
    chk("resync_no_partial", 32'(out_valid), 32'd0);
    send_bit(fbit(16'h00FF, 15), 1'b0);
    sin_valid = 1'b0;
    chk("resync_valid", 32'(out_valid), 32'd1);
    chk("resync_data", 32'(out_data), 32'h00FF);
    out_ready = 1'b1;
    idle(1);
    chk("resync_consumed", 32'(out_valid), 32'd0);

    // 6: back-to-back frames at full rate
    for (int f = 0; f < 4; f++) begin
      send_bit(fbit(b2b[f], 0), 1'b1);
      if (f > 0) chk("b2b_drained", 32'(out_valid), 32'd0);
      for (int k = 1; k < 16; k++) send_bit(fbit(b2b[f], k), 1'b0);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_data", 32'(out_data), 32'(b2b[f]));
    end
    idle(1);
    chk("b2b_final_drained", 32'(out_valid), 32'd0);
    chk("b2b_no_overrun", 32'(overrun), 32'd0);
    chk("b2b_no_sync_err", 32'(sync_err), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
